// File: rtl/motion_sequencer_pkg.sv
// Shared definitions for the two-axis motion sequencer: FSM states,
// motor command codes and the default angle modulus.
package motion_sequencer_pkg;

  localparam int ANG_MAX = 360;

  localparam logic [1:0] MOT_STOP = 2'b00;
  localparam logic [1:0] MOT_REV  = 2'b01;
  localparam logic [1:0] MOT_FWD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MOVE_TETA,
    MOVE_FI,
    AUTO,
    DONE
  } state_t;

  // Sensor comparator request -> motor command; 00 and 11 both mean hold.
  function automatic logic [1:0] auto_cmd(input logic [1:0] req);
    case (req)
      2'b01:   auto_cmd = MOT_REV;
      2'b10:   auto_cmd = MOT_FWD;
      default: auto_cmd = MOT_STOP;
    endcase
  endfunction

endpackage

// File: rtl/motion_sequencer_axis.sv
// axis_stepper: one axis position counter with modular wrap, plus the
// shortest-path direction toward a target. Knows nothing about step timing;
// the caller supplies a step enable and the command to apply.
module axis_stepper
  import motion_sequencer_pkg::*;
#(
  parameter int ANG_MOD = 360
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] target_i,
  input  logic        step_i,
  input  logic [1:0]  cmd_i,
  output logic [15:0] pos_o,
  output logic [1:0]  dir_o,
  output logic        step_o
);

  logic [15:0] pos_q, pos_d;
  logic        step_q, step_d;
  logic [16:0] diff_raw;
  logic [16:0] fwd_dist;

  // Forward distance (target - pos) mod ANG_MOD; both operands are already
  // inside 0..ANG_MOD-1 so a single conditional subtract is enough.
  assign diff_raw = {1'b0, target_i} + 17'(ANG_MOD) - {1'b0, pos_q};
  assign fwd_dist = (diff_raw >= 17'(ANG_MOD)) ? diff_raw - 17'(ANG_MOD) : diff_raw;

  // Shortest path; an exact half-turn resolves to forward.
  always_comb begin
    if (fwd_dist == '0)                      dir_o = MOT_STOP;
    else if (fwd_dist <= 17'(ANG_MOD / 2))   dir_o = MOT_FWD;
    else                                     dir_o = MOT_REV;
  end

  // Next position with wrap at both ends; step pulse accompanies each move.
  always_comb begin
    pos_d  = pos_q;
    step_d = 1'b0;
    if (step_i && cmd_i == MOT_FWD) begin
      pos_d  = (pos_q == 16'(ANG_MOD - 1)) ? '0 : pos_q + 16'd1;
      step_d = 1'b1;
    end else if (step_i && cmd_i == MOT_REV) begin
      pos_d  = (pos_q == '0) ? 16'(ANG_MOD - 1) : pos_q - 16'd1;
      step_d = 1'b1;
    end
  end

  // Position and step pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q  <= '0;
      step_q <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      step_q <= step_d;
    end
  end

  assign pos_o  = pos_q;
  assign step_o = step_q;

endmodule

// File: rtl/motion_sequencer.sv
// Two-axis motion sequencer: manual runs move teta then fi to latched
// targets along the shortest path; automatic runs step both axes from the
// sensor comparator requests. One shared step divider paces both axes.
module motion_sequencer
  import motion_sequencer_pkg::*;
#(
  parameter int STEP_DIV = 1000,
  parameter int ANG_MAX  = motion_sequencer_pkg::ANG_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic        abort,
  input  logic [15:0] teta_d,
  input  logic [15:0] fi_d,
  input  logic [1:0]  auto_teta,
  input  logic [1:0]  auto_fi,
  output logic [1:0]  s_out_teta,
  output logic [1:0]  s_out_fi,
  output logic        step_teta,
  output logic        step_fi,
  output logic [15:0] teta_pos,
  output logic [15:0] fi_pos,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int DIVW = $clog2(STEP_DIV);

  state_t            state_q, state_d;
  logic [15:0]       teta_tgt_q, teta_tgt_d;
  logic [15:0]       fi_tgt_q, fi_tgt_d;
  logic [DIVW-1:0]   div_q, div_d;
  logic              err_q, err_d;
  logic              tick;
  logic [1:0]        teta_dir, fi_dir;
  logic [1:0]        teta_cmd, fi_cmd;
  logic              teta_step_en, fi_step_en;

  assign tick = (div_q == DIVW'(STEP_DIV - 1));

  // Next-state, divider, target latch and motor command decode.
  always_comb begin
    state_d      = state_q;
    teta_tgt_d   = teta_tgt_q;
    fi_tgt_d     = fi_tgt_q;
    err_d        = 1'b0;
    div_d        = tick ? '0 : div_q + 1'b1;
    teta_cmd     = MOT_STOP;
    fi_cmd       = MOT_STOP;
    teta_step_en = 1'b0;
    fi_step_en   = 1'b0;

    case (state_q)
      IDLE: begin
        div_d = '0;
        if (start && !abort) begin
          if (!mode) begin
            state_d = AUTO;
          end else if (({1'b0, teta_d} < 17'(ANG_MAX)) && ({1'b0, fi_d} < 17'(ANG_MAX))) begin
            teta_tgt_d = teta_d;
            fi_tgt_d   = fi_d;
            state_d    = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        div_d   = '0;
        state_d = MOVE_TETA;
      end
      MOVE_TETA: begin
        teta_cmd = teta_dir;
        if (teta_dir == MOT_STOP) begin
          div_d   = '0;
          state_d = MOVE_FI;
        end else begin
          teta_step_en = tick;
        end
      end
      MOVE_FI: begin
        fi_cmd = fi_dir;
        if (fi_dir == MOT_STOP) begin
          state_d = DONE;
        end else begin
          fi_step_en = tick;
        end
      end
      AUTO: begin
        teta_cmd     = auto_cmd(auto_teta);
        fi_cmd       = auto_cmd(auto_fi);
        teta_step_en = tick;
        fi_step_en   = tick;
        if (mode) begin
          state_d      = IDLE;
          teta_step_en = 1'b0;
          fi_step_en   = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort beats everything else and freezes both axes where they are.
    if (abort && state_q != IDLE) begin
      state_d      = IDLE;
      teta_step_en = 1'b0;
      fi_step_en   = 1'b0;
    end
  end

  // State, divider, latched targets and error pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      teta_tgt_q <= '0;
      fi_tgt_q   <= '0;
      div_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      teta_tgt_q <= teta_tgt_d;
      fi_tgt_q   <= fi_tgt_d;
      div_q      <= div_d;
      err_q      <= err_d;
    end
  end

  axis_stepper #(.ANG_MOD(ANG_MAX)) u_teta (
    .clk      (clk),
    .rst      (rst),
    .target_i (teta_tgt_q),
    .step_i   (teta_step_en),
    .cmd_i    (teta_cmd),
    .pos_o    (teta_pos),
    .dir_o    (teta_dir),
    .step_o   (step_teta)
  );

  axis_stepper #(.ANG_MOD(ANG_MAX)) u_fi (
    .clk      (clk),
    .rst      (rst),
    .target_i (fi_tgt_q),
    .step_i   (fi_step_en),
    .cmd_i    (fi_cmd),
    .pos_o    (fi_pos),
    .dir_o    (fi_dir),
    .step_o   (step_fi)
  );

  assign s_out_teta = teta_cmd;
  assign s_out_fi   = fi_cmd;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_motion_sequencer.sv
// Bench for motion_sequencer with STEP_DIV = 4: directed runs, a plan of
// expected step positions built from shortest-path arithmetic, and a
// per-cycle monitor that checks every step against the plan.
module tb_motion_sequencer;

  localparam int SD = 4;
  localparam int AM = 360;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, mode = 1'b0, abort = 1'b0;
  logic [15:0] teta_d = '0, fi_d = '0;
  logic [1:0]  auto_teta = '0, auto_fi = '0;
  logic [1:0]  s_out_teta, s_out_fi;
  logic        step_teta, step_fi, busy, done, err;
  logic [15:0] teta_pos, fi_pos;

  motion_sequencer #(.STEP_DIV(SD), .ANG_MAX(AM)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .teta_d(teta_d), .fi_d(fi_d), .auto_teta(auto_teta), .auto_fi(auto_fi),
    .s_out_teta(s_out_teta), .s_out_fi(s_out_fi),
    .step_teta(step_teta), .step_fi(step_fi),
    .teta_pos(teta_pos), .fi_pos(fi_pos),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int exp_teta[0:399], exp_fi[0:399];
  int len_teta = 0, len_fi = 0;
  int idx_teta = 0, idx_fi = 0, last_teta = -1, last_fi = -1;
  int cyc = 0, done_cnt = 0, err_cnt = 0;
  bit prev_busy = 0, auto_run = 0, run_full = 0;
  int model_teta = 0, model_fi = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected positions after each step from pos toward tgt, shortest way round.
  task automatic plan(input int which, input int pos, input int tgt);
    int fwd, dir, n, p;
    fwd = (((tgt - pos) % AM) + AM) % AM;
    dir = (fwd == 0) ? 0 : ((2 * fwd <= AM) ? 1 : -1);
    n   = (dir == 1) ? fwd : ((dir == -1) ? AM - fwd : 0);
    p   = pos;
    for (int i = 0; i < n; i++) begin
      p = (p + dir + AM) % AM;
      if (which == 0) exp_teta[i] = p; else exp_fi[i] = p;
    end
    if (which == 0) len_teta = n; else len_fi = n;
  endtask

  // Per-cycle comparison of DUT outputs against the plan and the rules.
  task automatic monitor();
    if (rst) begin
      idx_teta = 0; idx_fi = 0; last_teta = -1; last_fi = -1; prev_busy = 0;
      return;
    end
    if (step_teta || step_fi || !busy) begin
      chk("sout_legal", int'(s_out_teta != 2'b11 && s_out_fi != 2'b11), 1);
    end
    if (!busy) chk("idle_outputs_quiet", int'({s_out_teta, s_out_fi, step_teta, step_fi}), 0);
    if (step_teta) begin
      chk("teta_step_within_plan", int'(idx_teta < len_teta), 1);
      if (idx_teta < len_teta) chk("teta_step_pos", teta_pos, exp_teta[idx_teta]);
      if (last_teta >= 0) chk("teta_step_gap", cyc - last_teta, SD);
      last_teta = cyc;
      idx_teta++;
    end
    if (step_fi) begin
      chk("fi_step_within_plan", int'(idx_fi < len_fi), 1);
      if (idx_fi < len_fi) chk("fi_step_pos", fi_pos, exp_fi[idx_fi]);
      if (!auto_run) chk("fi_after_teta_done", idx_teta, len_teta);
      if (last_fi >= 0) chk("fi_step_gap", cyc - last_fi, SD);
      last_fi = cyc;
      idx_fi++;
    end
    if (auto_run && (step_teta || step_fi)) chk("auto_concurrent", step_teta, step_fi);
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (prev_busy && !busy && run_full) begin
      chk("teta_steps_total", idx_teta, len_teta);
      chk("fi_steps_total", idx_fi, len_fi);
    end
    if (!busy) begin
      idx_teta = 0; idx_fi = 0; last_teta = -1; last_fi = -1;
    end
    prev_busy = busy;
  endtask

  task automatic cycle_chk();
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle_chk();
    cycle_chk();
    rst = 1'b0;
    model_teta = 0;
    model_fi = 0;
    cycle_chk();
  endtask

  // Manual run to (tt, ff); lat = cycles from the start-sampling edge to done.
  task automatic run_manual(input int tt, input int ff, output int lat);
    plan(0, model_teta, tt);
    plan(1, model_fi, ff);
    auto_run = 0; run_full = 1;
    teta_d = 16'(tt); fi_d = 16'(ff); mode = 1'b1; start = 1'b1;
    cycle_chk();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 3000) begin
      cycle_chk();
      lat++;
    end
    chk("done_seen", int'(done), 1);
    cycle_chk();
    model_teta = tt;
    model_fi = ff;
  endtask

  initial begin
    int lat, d0, n;
    do_reset();
    $display("reset: teta_pos=%0d fi_pos=%0d busy=%0d", teta_pos, fi_pos, busy);
    chk("reset_outputs", int'({s_out_teta, s_out_fi, step_teta, step_fi, busy, done, err}), 0);
    chk("reset_teta_pos", teta_pos, 0);
    chk("reset_fi_pos", fi_pos, 0);

    // Manual 10 / 350 from reset.
    d0 = done_cnt;
    run_manual(10, 350, lat);
    $display("manual 10/350: teta=%0d fi=%0d latency=%0d", teta_pos, fi_pos, lat);
    chk("plan_len_teta_10", len_teta, 10);
    chk("plan_len_fi_10", len_fi, 10);
    chk("m1_teta_pos", teta_pos, 10);
    chk("m1_fi_pos", fi_pos, 350);
    chk("m1_latency_82_84", int'(lat >= 82 && lat <= 84), 1);
    chk("m1_done_once", done_cnt - d0, 1);
    chk("m1_idle_after", busy, 0);

    // Half-turn tie goes forward.
    do_reset();
    run_manual(180, 0, lat);
    $display("manual 180: teta=%0d steps=%0d", teta_pos, len_teta);
    chk("plan_len_180", len_teta, 180);
    chk("m2_teta_pos", teta_pos, 180);

    // One past half-turn goes reverse through 359.
    do_reset();
    run_manual(181, 0, lat);
    $display("manual 181: teta=%0d steps=%0d", teta_pos, len_teta);
    chk("plan_len_181", len_teta, 179);
    chk("plan_first_181", exp_teta[0], 359);
    chk("m3_teta_pos", teta_pos, 181);

    // Out-of-range target is rejected.
    n = err_cnt;
    teta_d = 16'd10; fi_d = 16'd400; mode = 1'b1; start = 1'b1;
    cycle_chk();
    start = 1'b0;
    $display("reject fi=400: err=%0d busy=%0d", err, busy);
    chk("rej_err_pulse", err, 1);
    chk("rej_busy", busy, 0);
    cycle_chk();
    chk("rej_err_single", err, 0);
    chk("rej_err_count", err_cnt - n, 1);
    chk("rej_teta_pos", teta_pos, model_teta);
    chk("rej_fi_pos", fi_pos, model_fi);

    // Abort after 3 teta steps.
    do_reset();
    d0 = done_cnt;
    plan(0, 0, 10); plan(1, 0, 0);
    auto_run = 0; run_full = 0;
    teta_d = 16'd10; fi_d = 16'd0; mode = 1'b1; start = 1'b1;
    cycle_chk();
    start = 1'b0;
    n = 0;
    while (teta_pos != 16'd3 && n < 200) begin
      cycle_chk();
      n++;
    end
    chk("abort_reached_3", teta_pos, 3);
    abort = 1'b1;
    cycle_chk();
    abort = 1'b0;
    $display("abort: busy=%0d teta=%0d s_out=%0d", busy, teta_pos, s_out_teta);
    chk("abort_idle", busy, 0);
    chk("abort_teta_pos", teta_pos, 3);
    chk("abort_sout", int'({s_out_teta, s_out_fi}), 0);
    cycle_chk();
    chk("abort_no_done", done_cnt - d0, 0);

    // start and abort together in IDLE: nothing happens.
    teta_d = 16'd20; start = 1'b1; abort = 1'b1;
    cycle_chk();
    start = 1'b0; abort = 1'b0;
    cycle_chk();
    $display("start+abort: busy=%0d teta=%0d", busy, teta_pos);
    chk("startabort_idle", busy, 0);
    chk("startabort_pos", teta_pos, 3);

    // Reset mid-run returns positions to 0 without done.
    d0 = done_cnt;
    plan(0, 3, 20); plan(1, 0, 0);
    run_full = 0;
    teta_d = 16'd20; fi_d = 16'd0; mode = 1'b1; start = 1'b1;
    cycle_chk();
    start = 1'b0;
    n = 0;
    while (teta_pos != 16'd5 && n < 200) begin
      cycle_chk();
      n++;
    end
    do_reset();
    $display("reset mid-run: busy=%0d teta=%0d", busy, teta_pos);
    chk("midrst_idle", busy, 0);
    chk("midrst_teta_pos", teta_pos, 0);
    chk("midrst_no_done", done_cnt - d0, 0);

    // AUTO: teta forward, fi reverse, 5 ticks, then leave via mode.
    d0 = done_cnt;
    plan(0, 0, 5); plan(1, 0, 355);
    auto_run = 1; run_full = 1;
    auto_teta = 2'b10; auto_fi = 2'b01; mode = 1'b0; start = 1'b1;
    cycle_chk();
    start = 1'b0;
    chk("auto_busy", busy, 1);
    chk("auto_sout", int'({s_out_teta, s_out_fi}), 6'b0 + 4'b1001);
    n = 0;
    while (idx_teta < 5 && n < 200) begin
      cycle_chk();
      n++;
    end
    mode = 1'b1;
    cycle_chk();
    $display("auto exit: busy=%0d teta=%0d fi=%0d", busy, teta_pos, fi_pos);
    chk("auto_exit_idle", busy, 0);
    chk("auto_teta_pos", teta_pos, 5);
    chk("auto_fi_pos", fi_pos, 355);
    chk("auto_no_done", done_cnt - d0, 0);
    auto_run = 0;
    cycle_chk();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/motion_sequencer.md
MOTION_SEQUENCER -- requirements
Module: motion_sequencer

Interface
REQ-001 Parameter STEP_DIV, default 1000, clk cycles per motor step (min 2).
REQ-002 Parameter ANG_MAX, default 360, angle modulus in degrees.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  single-cycle request to begin a run; sampled only in IDLE.
REQ-007 mode  in  1  0 = automatic (sensor-driven), 1 = manual (angle targets).
REQ-008 abort  in  1  terminate any run immediately.
REQ-009 teta_d, fi_d  in  16 each  manual target angles, degrees.
REQ-010 auto_teta, auto_fi  in  2 each  direction requests from the sensor comparator (01 reverse, 10 forward, 00/11 hold).
REQ-011 s_out_teta, s_out_fi  out  2 each  motor commands (00 stop, 01 reverse, 10 forward).
REQ-012 step_teta, step_fi  out  1 each  one-cycle step pulses.
REQ-013 teta_pos, fi_pos  out  16 each  tracked axis positions, 0..ANG_MAX-1.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done, err  out  1 each  one-cycle completion and rejection pulses.

Function
REQ-016 States SHALL be IDLE, LOAD, MOVE_TETA, MOVE_FI, AUTO and DONE.
REQ-017 IDLE: start with mode=1 and both targets < ANG_MAX -> LOAD, with targets latched; start with mode=1 and either target >= ANG_MAX -> err pulse next cycle, stay IDLE; start with mode=0 -> AUTO.
REQ-018 LOAD (one cycle) SHALL compute the teta direction and go to MOVE_TETA.
REQ-019 Shortest path: fwd = (target - pos) mod ANG_MAX; fwd = 0 -> axis complete; fwd <= ANG_MAX/2 -> forward (10); otherwise reverse (01). A tie at 180 resolves to forward.
REQ-020 The step divider SHALL clear on entry to MOVE_TETA, MOVE_FI or AUTO, and tick every STEP_DIV cycles thereafter; the first tick occurs STEP_DIV cycles after entry.
REQ-021 On each tick of an active axis: one-cycle step pulse, and pos +1 (forward) or -1 (reverse), same cycle.
REQ-022 Wrap: forward from ANG_MAX-1 -> 0; reverse from 0 -> ANG_MAX-1.
REQ-023 MOVE_TETA: when teta_pos equals the latched target, s_out_teta = 00 and the state goes to MOVE_FI; the fi axis never moves while teta is unfinished.
REQ-024 MOVE_FI: same rule for fi; on completion -> DONE.
REQ-025 DONE: done = 1 for exactly one cycle, then IDLE.
REQ-026 AUTO: both axes step concurrently on each tick per auto_teta/auto_fi, sampled at the tick; 00/11 -> s_out = 00, no step.
REQ-027 AUTO exits to IDLE when mode=1 or abort; done is not pulsed.
REQ-028 abort in any non-IDLE state SHALL produce IDLE next cycle with both s_out = 00 and positions retained; no done or err.
REQ-029 abort and start in the same cycle: abort wins and start is ignored.
REQ-030 start while busy SHALL be ignored.
REQ-031 Outside MOVE/AUTO states, s_out_* = 00 and step_* = 0.

Reset
REQ-032 rst SHALL force IDLE; all outputs 0; teta_pos = fi_pos = 0; divider and latched targets cleared.
REQ-033 rst mid-run SHALL abandon the run with no done pulse, and positions SHALL return to 0.

Structure
REQ-034 A shared package SHALL hold the state enum, the motor codes (MOT_STOP, MOT_REV, MOT_FWD) and ANG_MAX.
REQ-035 A single sub-module, axis_stepper (divider-independent position counter with wrap and direction compute), SHALL be instantiated twice.

Verification (STEP_DIV = 4)
REQ-036 Manual from reset, teta_d=10, fi_d=350 -> 10 forward teta steps then 10 reverse fi steps; final teta_pos=10, fi_pos=350; done once, 82-84 cycles after start.
REQ-037 Manual teta_d=180 -> 180 forward steps; then from 0, teta_d=181 -> 179 reverse steps through 359.
REQ-038 Manual fi_d=400 -> err pulse one cycle after start; busy stays 0; positions unchanged.
REQ-039 Abort after 3 teta steps toward 10 -> IDLE next cycle, teta_pos=3, s_out 00, no done; start+abort same cycle -> stays IDLE.
REQ-040 AUTO with auto_teta=10, auto_fi=01 for 5 ticks from reset -> teta_pos=5, fi_pos=355; mode to 1 -> IDLE with no done.
